// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding command-to-APB4 master with wait-state timeout and error counting
module apb_cmd_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                psel,
    output logic                penable,
    output logic [ADDR_W-1:0]   paddr,
    output logic                pwrite,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr,
    output logic [15:0]         err_cnt
);
    localparam int WC_W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC + 1) : 1;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state, state_n;
    logic [WC_W-1:0] wcnt;
    logic hs, tmo, done, err_n, ready_n, psel_n, pen_n, valid_n;
    logic [DATA_W-1:0] rdata_n;
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    // Timeout fires on the TIMEOUT_CYC-th waited ACCESS cycle; pready wins the same cycle
    always_comb begin
        hs = state == IDLE && cmd_valid && cmd_ready;
        tmo = TIMEOUT_CYC != 0 && wcnt == WC_W'(TIMEOUT_CYC - 1);
        done = state == ACCESS && (pready || tmo);
        state_n = state == IDLE   ? (hs ? SETUP : IDLE) :
                  state == SETUP  ? ACCESS :
                  state == ACCESS ? (done ? RESP : ACCESS) :
                  rsp_ready       ? IDLE : RESP;
    end
    always_comb begin
        ready_n = state_n == IDLE;
        psel_n = state_n == SETUP || state_n == ACCESS;
        pen_n = state_n == ACCESS;
        valid_n = state_n == RESP;
        err_n = pready ? pslverr : 1'b1;
        rdata_n = pready && !pwrite ? prdata : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready   <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b0;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
            wcnt        <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            err_cnt     <= '0;
        end else begin
            cmd_ready <= ready_n;
            psel      <= psel_n;
            penable   <= pen_n;
            rsp_valid <= valid_n;
            if (hs) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_wdata;
                pstrb  <= cmd_write ? cmd_strb : '0;
            end
            wcnt <= hs ? '0 : (state == ACCESS && !pready) ? wcnt + 1'b1 : wcnt;
            if (done) begin
                rsp_rdata   <= rdata_n;
                rsp_err     <= err_n;
                rsp_timeout <= !pready;
                if (err_n && err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: random and directed transfers checked against a per-transfer outcome model
module tb_apb_cmd_master;
    localparam int TO = 16;
    logic clk = 1'b0, rst = 1'b1;
    logic cmd_valid = 0, cmd_ready, cmd_write = 0;
    logic [31:0] cmd_addr = 0, cmd_wdata = 0;
    logic [3:0] cmd_strb = 0;
    logic rsp_valid, rsp_ready = 0, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata = 0;
    logic [3:0] pstrb;
    logic pready = 0, pslverr = 0;
    logic [15:0] err_cnt;
    logic [15:0] mdl_errcnt = 0;
    int n_vec = 0, n_bad = 0;

    apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic jitter();
        pready = 1'($urandom);
        pslverr = 1'($urandom);
        prdata = $urandom;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    endtask

    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input int waits, input logic slv,
                        input logic [31:0] rd, input int rdly);
        logic exp_to, exp_err, hold_ok, apb_ok;
        logic [31:0] exp_rd;
        int exp_acc, acc, cyc;
        exp_to = TO != 0 && waits >= TO;
        exp_acc = exp_to ? TO : waits + 1;
        exp_err = exp_to || slv;
        exp_rd = (exp_to || wr) ? 32'h0 : rd;
        wait_ready();
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_strb = st;
        @(negedge clk);
        cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        cmd_strb = 4'($urandom);
        cyc = 1;
        check("setup_phase", 64'({psel, penable}), 64'(2'b10));
        check("paddr", 64'(paddr), 64'(a));
        check("pwrite", 64'(pwrite), 64'(wr));
        check("pwdata", 64'(pwdata), 64'(wd));
        check("pstrb", 64'(pstrb), 64'(wr ? st : 4'h0));
        check("cmd_ready_busy", 64'(cmd_ready), 64'(0));
        jitter();
        @(negedge clk);
        cyc++;
        acc = 0;
        apb_ok = 1;
        while (psel && penable && acc < 40) begin
            acc++;
            if (paddr !== a || pwrite !== wr || pwdata !== wd || pstrb !== (wr ? st : 4'h0))
                apb_ok = 0;
            pready = acc > waits;
            pslverr = pready ? slv : 1'($urandom);
            prdata = pready ? rd : $urandom;
            @(negedge clk);
            cyc++;
        end
        jitter();
        check("apb_hold", 64'(apb_ok), 64'(1));
        check("access_cycles", 64'(acc), 64'(exp_acc));
        check("resp_apb_idle", 64'({psel, penable}), 64'(0));
        check("rsp_valid", 64'(rsp_valid), 64'(1));
        check("rsp_err", 64'(rsp_err), 64'(exp_err));
        check("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        if (exp_err && mdl_errcnt != 16'hFFFF)
            mdl_errcnt = mdl_errcnt + 16'h1;
        check("err_cnt", 64'(err_cnt), 64'(mdl_errcnt));
        hold_ok = 1;
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            cyc++;
            jitter();
            if (rsp_valid !== 1'b1 || rsp_err !== exp_err || rsp_timeout !== exp_to ||
                rsp_rdata !== exp_rd || cmd_ready !== 1'b0)
                hold_ok = 0;
        end
        check("rsp_hold", 64'(hold_ok), 64'(1));
        rsp_ready = 1;
        @(negedge clk);
        cyc++;
        rsp_ready = 0;
        check("rsp_drop", 64'(rsp_valid), 64'(0));
        check("cmd_ready_back", 64'(cmd_ready), 64'(1));
        check("xfer_cycles", 64'(cyc), 64'(exp_acc + rdly + 3));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outs", 64'({cmd_ready, psel, penable, rsp_valid, rsp_err, rsp_timeout, pwrite}), 64'(0));
        check("reset_bus", 64'({paddr, pstrb}), 64'(0));
        check("reset_rsp", 64'({rsp_rdata, err_cnt}), 64'(0));
        rst = 0;
        @(negedge clk);
        check("ready_after_rst", 64'(cmd_ready), 64'(1));
        xfer(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 0, 1'b0, 32'hDEADBEEF, 0);
        xfer(1'b0, 32'h20, 32'h0, 4'hF, 3, 1'b0, 32'h12345678, 0);
        xfer(1'b0, 32'h30, 32'h0, 4'h0, 1000, 1'b0, 32'hCAFEF00D, 1);
        xfer(1'b1, 32'h40, 32'h11223344, 4'h5, 0, 1'b1, 32'h0, 5);
        xfer(1'b0, 32'h44, 32'h0, 4'h3, TO - 1, 1'b0, 32'h87654321, 0);
        xfer(1'b0, 32'h48, 32'h0, 4'h3, TO, 1'b0, 32'h87654321, 0);
        for (int t = 0; t < 30; t++)
            xfer(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 20)),
                 1'($urandom), $urandom, int'($urandom_range(0, 3)));
        wait_ready();
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h50;
        @(negedge clk);
        cmd_valid = 0; pready = 0;
        @(negedge clk);
        check("pre_rst_access", 64'({psel, penable}), 64'(2'b11));
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("rst_abort", 64'({psel, penable, rsp_valid, cmd_ready}), 64'(0));
        check("rst_errcnt", 64'(err_cnt), 64'(0));
        rst = 0;
        mdl_errcnt = 0;
        @(negedge clk);
        check("ready_after_abort", 64'(cmd_ready), 64'(1));
        xfer(1'b0, 32'h54, 32'h0, 4'h0, 2, 1'b0, 32'h0BADF00D, 1);
        force dut.err_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.err_cnt;
        mdl_errcnt = 16'hFFFE;
        @(negedge clk);
        check("errcnt_preload", 64'(err_cnt), 64'(16'hFFFE));
        xfer(1'b1, 32'h60, 32'h1, 4'h1, 0, 1'b1, 32'h0, 0);
        xfer(1'b0, 32'h64, 32'h0, 4'h0, 1, 1'b1, 32'h5, 0);
        check("errcnt_sat", 64'(err_cnt), 64'(16'hFFFF));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width in bits; legal values 8, 16, 32.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16, the maximum number of ACCESS cycles with pready low; 0 disables the timeout.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_ready  output  1  command accept.
REQ-008 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr  input  ADDR_W  target address.
REQ-010 SHALL have port cmd_wdata  input  DATA_W  write data.
REQ-011 SHALL have port cmd_strb  input  DATA_W/8  write byte strobes.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  response consumed.
REQ-014 SHALL have port rsp_rdata  output  DATA_W  read data; 0 for writes, errors and timeouts.
REQ-015 SHALL have port rsp_err  output  1  pslverr seen or timeout.
REQ-016 SHALL have port rsp_timeout  output  1  transfer terminated by the timeout.
REQ-017 SHALL have APB4 outputs psel 1, penable 1, paddr ADDR_W, pwrite 1, pwdata DATA_W, and pstrb DATA_W/8.
REQ-018 SHALL have APB4 inputs prdata DATA_W, pready 1, and pslverr 1.
REQ-019 SHALL have port err_cnt  output  16  saturating count of error responses.

Function
REQ-020 SHALL implement the states IDLE, SETUP, ACCESS and RESP, and SHALL drive every output from a register.
REQ-021 SHALL drive cmd_ready=1 only in IDLE; a command handshake SHALL occur only when cmd_valid and cmd_ready are both 1.
REQ-022 SHALL, on a handshake, capture addr, write, wdata and strb in the same edge and move IDLE->SETUP.
REQ-023 SHALL, in SETUP, drive psel=1 and penable=0 with paddr, pwrite and pwdata set from the captured command, then move to ACCESS unconditionally after 1 cycle.
REQ-024 SHALL, in ACCESS, drive psel=1 and penable=1, and SHALL hold paddr, pwrite, pwdata and pstrb stable until the state is left.
REQ-025 SHALL drive pstrb = captured strb for writes and all-zero for reads.
REQ-026 SHALL, in ACCESS with pready=1, capture rsp_rdata=prdata (reads only, else 0) and rsp_err=pslverr, set rsp_timeout=0, and move to RESP.
REQ-027 SHALL count ACCESS cycles with pready=0 in a wait counter that is cleared on entry to SETUP.
REQ-028 SHALL, when TIMEOUT_CYC!=0 and the wait counter reaches TIMEOUT_CYC with pready still 0, move to RESP with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-029 SHALL give pready=1 priority over the timeout in the same cycle.
REQ-030 SHALL deassert psel and penable on the edge that leaves ACCESS, so they are 0 in RESP.
REQ-031 SHALL, in RESP, drive rsp_valid=1 and hold the rsp_* outputs stable until rsp_ready=1, then move to IDLE; rsp_valid SHALL drop on that edge.
REQ-032 SHALL increment err_cnt by 1 per RESP entry with rsp_err=1, and SHALL saturate err_cnt at 16'hFFFF.
REQ-033 SHALL ignore pready, pslverr and prdata outside ACCESS.
REQ-034 SHALL take a minimum of 4 cycles per transfer, command handshake to the next cmd_ready, with zero wait states and rsp_ready held at 1.

Reset
REQ-035 SHALL, while rst=1, force state IDLE and hold all APB outputs, rsp_*, err_cnt and the wait counter at 0.
REQ-036 SHALL hold cmd_ready at 0 while rst=1 and drive it to 1 in the first cycle after rst falls.
REQ-037 SHALL, on rst asserted in mid-transfer, abandon the transfer: psel and penable SHALL be 0 after the next edge and no response SHALL be produced.

Verification
REQ-038 SHALL be verified with: write addr 0x10, wdata 0xA5A5A5A5, strb 0xF, pready=1 at once -> SETUP 1 cycle, ACCESS 1 cycle, pstrb=0xF, rsp_valid with rsp_err=0 and rsp_rdata=0.
REQ-039 SHALL be verified with: read addr 0x20, pready low 3 cycles, prdata=0x12345678 -> ACCESS lasts 4 cycles, pstrb=0, rsp_rdata=0x12345678.
REQ-040 SHALL be verified with: read, pready never asserted, TIMEOUT_CYC=16 -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_timeout=1, rsp_rdata=0, and err_cnt increments 0->1.
REQ-041 SHALL be verified with: write with pslverr=1 and rsp_ready low 5 cycles -> rsp_valid and rsp_err held stable for 5 cycles, cmd_ready=0 until rsp_ready.
REQ-042 SHALL be verified with: rst pulsed during ACCESS -> psel=0, penable=0 and rsp_valid=0 the next cycle, then a new command completes normally.
REQ-043 SHALL be verified with: err_cnt preloaded by forcing 0xFFFE, then 2 error responses -> err_cnt reads 0xFFFF after both.
